max_frame_sequencer: RTL and testbench

//  Sequences a shared find_max unit (3-input unsigned max, WIDTH bits) over a frame of input samples.

---
 rtl/max_frame_sequencer.sv | 178 +++++++++++++++++
 tb/tb_max_frame_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/max_frame_sequencer.sv
// Frame-maximum sequencer: folds a frame of unsigned samples through one shared
// 3-input max unit and hands the result to a consumer over valid/ready.

module find_max #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] ab_s;

    // Two-stage unsigned compare tree
    always_comb begin
        ab_s = (a >= b) ? a : b;
        y    = (ab_s >= c) ? ab_s : c;
    end

endmodule

module max_frame_sequencer #(
    parameter int WIDTH     = 3,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [CNT_W-1:0] out_count,
    output logic [7:0]       frames_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_r, state_n_s;
    logic [WIDTH-1:0] acc_r, acc_n_s;
    logic [WIDTH-1:0] pend_r, pend_n_s;
    logic             pend_vld_r, pend_vld_n_s;
    logic [CNT_W-1:0] cnt_r, cnt_n_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_max_r;
    logic [CNT_W-1:0] out_count_r;
    logic [7:0]       frames_done_r;

    logic             accept_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             last_s;
    logic             frame_end_s;
    logic [WIDTH-1:0] fm_b_s, fm_c_s, fm_y_s;

    find_max #(.WIDTH(WIDTH)) u_find_max (
        .a (acc_r),
        .b (fm_b_s),
        .c (fm_c_s),
        .y (fm_y_s)
    );

    // Accept/frame-end decode and max-unit operand steering; in_data only reaches
    // the max unit on an accept, otherwise the minimum value 0 takes its place.
    always_comb begin
        accept_s    = in_valid & in_ready_r;
        cnt_inc_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        last_s      = accept_s && (cnt_inc_s == CNT_W'(FRAME_LEN));
        frame_end_s = last_s || (flush && ((state_r == S_ACCUM) || accept_s));
        if (pend_vld_r) begin
            fm_b_s = pend_r;
        end else if (accept_s) begin
            fm_b_s = in_data;
        end else begin
            fm_b_s = {WIDTH{1'b0}};
        end
        if (accept_s && pend_vld_r) begin
            fm_c_s = in_data;
        end else begin
            fm_c_s = {WIDTH{1'b0}};
        end
    end

    // Next-state and accumulator update
    always_comb begin
        state_n_s    = state_r;
        acc_n_s      = acc_r;
        pend_n_s     = pend_r;
        pend_vld_n_s = pend_vld_r;
        cnt_n_s      = cnt_r;
        case (state_r)
            S_IDLE, S_ACCUM: begin
                if (frame_end_s) begin
                    acc_n_s      = fm_y_s;
                    pend_vld_n_s = 1'b0;
                    cnt_n_s      = accept_s ? cnt_inc_s : cnt_r;
                    state_n_s    = S_DONE;
                end else if (accept_s) begin
                    cnt_n_s   = cnt_inc_s;
                    state_n_s = S_ACCUM;
                    if (pend_vld_r) begin
                        acc_n_s      = fm_y_s;
                        pend_vld_n_s = 1'b0;
                    end else begin
                        pend_n_s     = in_data;
                        pend_vld_n_s = 1'b1;
                    end
                end else begin
                    state_n_s = state_r;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_n_s    = S_IDLE;
                    acc_n_s      = {WIDTH{1'b0}};
                    cnt_n_s      = {CNT_W{1'b0}};
                    pend_vld_n_s = 1'b0;
                end else begin
                    state_n_s = S_DONE;
                end
            end
            default: begin
                state_n_s    = S_IDLE;
                acc_n_s      = {WIDTH{1'b0}};
                cnt_n_s      = {CNT_W{1'b0}};
                pend_vld_n_s = 1'b0;
            end
        endcase
    end

    // State, datapath and registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            acc_r         <= {WIDTH{1'b0}};
            pend_r        <= {WIDTH{1'b0}};
            pend_vld_r    <= 1'b0;
            cnt_r         <= {CNT_W{1'b0}};
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            out_max_r     <= {WIDTH{1'b0}};
            out_count_r   <= {CNT_W{1'b0}};
            frames_done_r <= 8'd0;
        end else begin
            state_r    <= state_n_s;
            acc_r      <= acc_n_s;
            pend_r     <= pend_n_s;
            pend_vld_r <= pend_vld_n_s;
            cnt_r      <= cnt_n_s;
            in_ready_r <= (state_n_s != S_DONE);
            if (frame_end_s) begin
                out_valid_r   <= 1'b1;
                out_max_r     <= fm_y_s;
                out_count_r   <= cnt_n_s;
                frames_done_r <= frames_done_r + 8'd1;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_max     = out_max_r;
    assign out_count   = out_count_r;
    assign frames_done = frames_done_r;

endmodule

// File: tb/tb_max_frame_sequencer.sv
// Directed self-checking bench for max_frame_sequencer (WIDTH=3, FRAME_LEN=4).

module tb_max_frame_sequencer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_data;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_max;
    logic [2:0] out_count;
    logic [7:0] frames_done;

    int checks;
    int failures;
    logic [7:0] exp_fd;

    max_frame_sequencer #(.WIDTH(3), .FRAME_LEN(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_max     (out_max),
        .out_count   (out_count),
        .frames_done (frames_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One accepted sample (optionally with flush), then inputs idle again
    task automatic send(input logic [2:0] d, input logic fl);
        in_valid = 1'b1;
        in_data  = d;
        flush    = fl;
        tick();
        in_valid = 1'b0;
        in_data  = 3'd0;
        flush    = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 3'd0;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_max", 32'(out_max), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_frames_done", 32'(frames_done), 32'd0);

        // T1: full frame 5,4,1,3
        send(3'd5, 1'b0);
        chk("t1_no_early_valid", 32'(out_valid), 32'd0);
        send(3'd4, 1'b0);
        send(3'd1, 1'b0);
        send(3'd3, 1'b0);
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_max", 32'(out_max), 32'd5);
        chk("t1_out_count", 32'(out_count), 32'd4);
        chk("t1_frames_done", 32'(frames_done), 32'd1);
        chk("t1_in_ready_done", 32'(in_ready), 32'd0);
        tick();
        chk("t1_out_valid_clr", 32'(out_valid), 32'd0);
        chk("t1_in_ready_back", 32'(in_ready), 32'd1);

        // T2: flush on third accept, then flush alone in IDLE
        send(3'd2, 1'b0);
        send(3'd3, 1'b0);
        send(3'd0, 1'b1);
        chk("t2_out_valid", 32'(out_valid), 32'd1);
        chk("t2_out_max", 32'(out_max), 32'd3);
        chk("t2_out_count", 32'(out_count), 32'd3);
        chk("t2_frames_done", 32'(frames_done), 32'd2);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("t2_idle_flush_valid", 32'(out_valid), 32'd0);
        chk("t2_idle_flush_fd", 32'(frames_done), 32'd2);
        chk("t2_idle_flush_ready", 32'(in_ready), 32'd1);

        // T3: backpressure, inputs in DONE ignored
        out_ready = 1'b0;
        send(3'd7, 1'b0);
        send(3'd0, 1'b0);
        send(3'd0, 1'b0);
        send(3'd0, 1'b0);
        chk("t3_out_valid", 32'(out_valid), 32'd1);
        chk("t3_out_max", 32'(out_max), 32'd7);
        in_valid = 1'b1;
        in_data  = 3'd6;
        flush    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_hold_valid", 32'(out_valid), 32'd1);
            chk("t3_hold_max", 32'(out_max), 32'd7);
            chk("t3_hold_count", 32'(out_count), 32'd4);
            chk("t3_hold_in_ready", 32'(in_ready), 32'd0);
            chk("t3_hold_fd", 32'(frames_done), 32'd3);
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t3_release_valid", 32'(out_valid), 32'd0);
        chk("t3_release_ready", 32'(in_ready), 32'd1);

        // T4: max as last sample; single sample then bare flush
        send(3'd1, 1'b0);
        send(3'd1, 1'b0);
        send(3'd1, 1'b0);
        send(3'd7, 1'b0);
        chk("t4_last_max", 32'(out_max), 32'd7);
        chk("t4_fd", 32'(frames_done), 32'd4);
        tick();
        send(3'd6, 1'b0);
        chk("t4_single_no_valid", 32'(out_valid), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_flush_valid", 32'(out_valid), 32'd1);
        chk("t4_flush_max", 32'(out_max), 32'd6);
        chk("t4_flush_count", 32'(out_count), 32'd1);
        chk("t4_flush_fd", 32'(frames_done), 32'd5);
        tick();

        // T5: reset mid-frame discards 7,7
        send(3'd7, 1'b0);
        send(3'd7, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_fd", 32'(frames_done), 32'd0);
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_ready", 32'(in_ready), 32'd1);
        send(3'd2, 1'b0);
        send(3'd1, 1'b0);
        send(3'd0, 1'b0);
        send(3'd0, 1'b0);
        chk("t5_out_max", 32'(out_max), 32'd2);
        chk("t5_out_count", 32'(out_count), 32'd4);
        chk("t5_fd", 32'(frames_done), 32'd1);
        tick();

        // T6: 256 zero frames, frames_done wraps 255 -> 0
        exp_fd = 8'd1;
        for (int f = 0; f < 256; f++) begin
            for (int s = 0; s < 4; s++) begin
                send(3'd0, 1'b0);
            end
            exp_fd = exp_fd + 8'd1;
            chk("t6_out_valid", 32'(out_valid), 32'd1);
            chk("t6_out_max", 32'(out_max), 32'd0);
            chk("t6_fd", 32'(frames_done), 32'(exp_fd));
            if (exp_fd == 8'd255) begin
                chk("t6_fd_at_255", 32'(frames_done), 32'd255);
            end else if (exp_fd == 8'd0) begin
                chk("t6_fd_wrapped", 32'(frames_done), 32'd0);
            end
            tick();
        end
        chk("t6_fd_final", 32'(frames_done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
